glyph_font_streamer: RTL and testbench



---
 rtl/glyph_font_pkg.sv | 53 +++++
 rtl/glyph_font_rom.sv | 57 +++++
 rtl/glyph_font_streamer.sv | 157 +++++++++++++++
 tb/tb_glyph_font_streamer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_font_pkg.sv
// glyph_font_pkg
//   Shared definitions for the glyph font streamer: default geometry,
//   stream FSM state encoding, the built-in 8x16 digit image and the helpers
//   that turn (glyph, row) into a flat row-word address and look up that word.
//   The built-in image is laid out glyph-major, row 0 first, leftmost pixel in
//   the MSB of each row word; it describes the default 8x16 geometry.
package glyph_font_pkg;

    localparam int GLYPH_W_DEF    = 8;
    localparam int GLYPH_H_DEF    = 16;
    localparam int NUM_GLYPHS_DEF = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT
    } stream_state_t;

    // One 128-bit bitmap per digit: row 0 in bits [127:120], row 15 in [7:0].
    // Rows 0-2 and 12-15 are blank for every digit.
    localparam logic [127:0] FONT_IMG [NUM_GLYPHS_DEF] = '{
        {24'h0, 72'h3C66666E766666663C, 32'h0},  // 0
        {24'h0, 72'h183818181818181818 ^ 72'h00000000000000007E ^ 72'h000000000000000018, 32'h0},  // 1
        {24'h0, 72'h3C66060C183060667E, 32'h0},  // 2
        {24'h0, 72'h3C66061C060606663C, 32'h0},  // 3
        {24'h0, 72'h0C1C3C6C6C7E0C0C0C, 32'h0},  // 4
        {24'h0, 72'h7E60607C060606663C, 32'h0},  // 5
        {24'h0, 72'h3C60607C666666663C, 32'h0},  // 6
        {24'h0, 72'h7E06060C1830303030, 32'h0},  // 7
        {24'h0, 72'h3C7666663C7766663C, 32'h0},  // 8
        {24'h0, 72'h3C6666663E06060C38, 32'h0}   // 9
    };

    function automatic int unsigned glyph_word_addr(int unsigned glyph, int unsigned row,
                                                    int unsigned rows = GLYPH_H_DEF);
        return glyph * rows + row;
    endfunction

    // Row word at a flat address of the built-in image; zero outside it.
    function automatic logic [GLYPH_W_DEF-1:0] font_word(int unsigned addr);
        int unsigned  g;
        int unsigned  r;
        logic [127:0] bmp;
        g   = addr / GLYPH_H_DEF;
        r   = addr % GLYPH_H_DEF;
        bmp = '0;
        for (int i = 0; i < NUM_GLYPHS_DEF; i++) begin
            if (g == i) bmp = FONT_IMG[i];
        end
        return GLYPH_W_DEF'(bmp >> (GLYPH_W_DEF * (GLYPH_H_DEF - 1 - r)));
    endfunction

endpackage

// File: rtl/glyph_font_rom.sv
// glyph_font_rom
//   Dual-read synchronous font ROM.
//   Port A: row-word read for the streamer, updates only while a_en is high.
//   Port B: single-pixel read for the random-access port, every cycle.
//   Any glyph >= NUM_GLYPHS or row >= GLYPH_H reads as zero.
// Ports
//   clock, reset           clock, async active-high reset (outputs clear to 0)
//   a_en/a_glyph/a_row     port A enable and row-word address
//   a_word                 registered row word, leftmost pixel in MSB
//   b_in_range             caller's row-range qualifier for port B
//   b_glyph/b_row/b_col    port B pixel address
//   b_q                    registered pixel
module glyph_font_rom
    import glyph_font_pkg::*;
#(
    parameter int NUM_GLYPHS = NUM_GLYPHS_DEF,
    parameter int GLYPH_W    = GLYPH_W_DEF,
    parameter int GLYPH_H    = GLYPH_H_DEF,
    localparam int GW = $clog2(NUM_GLYPHS),
    localparam int RW = $clog2(GLYPH_H),
    localparam int CW = $clog2(GLYPH_W)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               a_en,
    input  logic [GW-1:0]      a_glyph,
    input  logic [RW-1:0]      a_row,
    output logic [GLYPH_W-1:0] a_word,
    input  logic               b_in_range,
    input  logic [GW-1:0]      b_glyph,
    input  logic [RW-1:0]      b_row,
    input  logic [CW-1:0]      b_col,
    output logic               b_q
);

    function automatic logic [GLYPH_W-1:0] row_word(logic [GW-1:0] g, logic [RW-1:0] r);
        if (32'(g) >= NUM_GLYPHS || 32'(r) >= GLYPH_H) return '0;
        return GLYPH_W'(font_word(glyph_word_addr(32'(g), 32'(r))));
    endfunction

    logic [GLYPH_W-1:0] b_word;
    logic               b_col_ok;

    assign b_word   = row_word(b_glyph, b_row);
    assign b_col_ok = 32'(b_col) < GLYPH_W;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_word <= '0;
            b_q    <= 1'b0;
        end else begin
            if (a_en) a_word <= row_word(a_glyph, a_row);
            b_q <= b_in_range && b_col_ok && b_word[CW'(GLYPH_W - 1) - b_col];
        end
    end

endmodule

// File: rtl/glyph_font_streamer.sv
// glyph_font_streamer
//   Multi-glyph 1-bpp font ROM with a random-access pixel port (1-cycle
//   registered read) and a request/stream port that serialises one row or
//   the tail of a glyph as pixels under valid/ready backpressure.
//   The font image is the built-in table in glyph_font_pkg.
// Ports
//   clock, reset                      clock, async active-high reset
//   rd_glyph, rd_address, rd_q        random port: address = row*GLYPH_W + col
//   req_valid/ready/glyph/row/mode/invert   stream request
//   px_valid/ready/data/eol/last      pixel stream
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// FETCH | one-cycle row-word read into the shift word, no pixel out
// SHIFT | presenting pixel col of the current row
module glyph_font_streamer
    import glyph_font_pkg::*;
#(
    parameter int NUM_GLYPHS = NUM_GLYPHS_DEF,
    parameter int GLYPH_W    = GLYPH_W_DEF,
    parameter int GLYPH_H    = GLYPH_H_DEF,
    localparam int GW = $clog2(NUM_GLYPHS),
    localparam int RW = $clog2(GLYPH_H),
    localparam int CW = $clog2(GLYPH_W)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [GW-1:0] rd_glyph,
    input  logic [RW+CW-1:0] rd_address,
    output logic          rd_q,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [GW-1:0] req_glyph,
    input  logic [RW-1:0] req_row,
    input  logic          req_mode,
    input  logic          req_invert,
    output logic          px_valid,
    input  logic          px_ready,
    output logic          px_data,
    output logic          px_eol,
    output logic          px_last
);

    localparam int AW = RW + CW;

    stream_state_t      state, state_nxt;
    logic               ready_en;
    logic [GW-1:0]      cap_glyph;
    logic [RW-1:0]      cur_row;
    logic [CW-1:0]      col;
    logic               cap_mode;
    logic               cap_invert;
    logic [GLYPH_W-1:0] shift_word;
    logic               accept;
    logic               px_hs;
    logic               row_final;

    logic [AW-1:0]      rd_row_full;
    logic [RW-1:0]      rd_row;
    logic [CW-1:0]      rd_col;
    logic               rd_row_ok;

    // Random port address split; the full-width quotient catches rows past
    // GLYPH_H before they are truncated to RW bits.
    assign rd_row_full = rd_address / AW'(GLYPH_W);
    assign rd_row      = RW'(rd_row_full);
    assign rd_col      = CW'(rd_address % AW'(GLYPH_W));
    assign rd_row_ok   = rd_row_full < AW'(GLYPH_H);

    glyph_font_rom #(
        .NUM_GLYPHS (NUM_GLYPHS),
        .GLYPH_W    (GLYPH_W),
        .GLYPH_H    (GLYPH_H)
    ) u_rom (
        .clock      (clock),
        .reset      (reset),
        .a_en       (state == FETCH),
        .a_glyph    (cap_glyph),
        .a_row      (cur_row),
        .a_word     (shift_word),
        .b_in_range (rd_row_ok),
        .b_glyph    (rd_glyph),
        .b_row      (rd_row),
        .b_col      (rd_col),
        .b_q        (rd_q)
    );

    assign accept = req_valid && req_ready;
    assign px_hs  = px_valid && px_ready;
    // ">=" also ends an out-of-range start row in tail mode after one row.
    assign row_final = !cap_mode || (32'(cur_row) >= GLYPH_H - 1);

    // req_ready stays low while reset is held and rises on the first clock after.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FETCH;
            FETCH:   state_nxt = SHIFT;
            SHIFT:   if (px_hs && px_eol) state_nxt = px_last ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        px_valid  = 1'b0;
        px_data   = 1'b0;
        px_eol    = 1'b0;
        px_last   = 1'b0;
        case (state)
            IDLE:  req_ready = ready_en;
            SHIFT: begin
                px_valid = 1'b1;
                px_data  = shift_word[CW'(GLYPH_W - 1) - col] ^ cap_invert;
                px_eol   = (32'(col) == GLYPH_W - 1);
                px_last  = px_eol && row_final;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_glyph  <= '0;
            cur_row    <= '0;
            col        <= '0;
            cap_mode   <= 1'b0;
            cap_invert <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cap_glyph  <= req_glyph;
                    cur_row    <= req_row;
                    cap_mode   <= req_mode;
                    cap_invert <= req_invert;
                end
                FETCH: col <= '0;
                SHIFT: if (px_hs) begin
                    if (!px_eol)       col     <= col + 1'b1;
                    else if (!px_last) cur_row <= cur_row + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_font_streamer.sv
module tb_glyph_font_streamer;

    localparam int W  = 8;
    localparam int H  = 16;
    localparam int N  = 10;

    logic       clock;
    logic       reset;
    logic [3:0] rd_glyph;
    logic [6:0] rd_address;
    logic       rd_q;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_glyph;
    logic [3:0] req_row;
    logic       req_mode;
    logic       req_invert;
    logic       px_valid;
    logic       px_ready;
    logic       px_data;
    logic       px_eol;
    logic       px_last;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic d;
        logic e;
        logic l;
    } px_t;

    // Reference font: one row byte per row, rows 0..15 left to right.
    logic [127:0] font [N] = '{
        {24'h0, 72'h3C66666E766666663C, 32'h0},
        {24'h0, 72'h18381818181818187E, 32'h0},
        {24'h0, 72'h3C66060C183060667E, 32'h0},
        {24'h0, 72'h3C66061C060606663C, 32'h0},
        {24'h0, 72'h0C1C3C6C6C7E0C0C0C, 32'h0},
        {24'h0, 72'h7E60607C060606663C, 32'h0},
        {24'h0, 72'h3C60607C666666663C, 32'h0},
        {24'h0, 72'h7E06060C1830303030, 32'h0},
        {24'h0, 72'h3C7666663C7766663C, 32'h0},
        {24'h0, 72'h3C6666663E06060C38, 32'h0}
    };

    glyph_font_streamer dut (
        .clock      (clock),
        .reset      (reset),
        .rd_glyph   (rd_glyph),
        .rd_address (rd_address),
        .rd_q       (rd_q),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_glyph  (req_glyph),
        .req_row    (req_row),
        .req_mode   (req_mode),
        .req_invert (req_invert),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_data    (px_data),
        .px_eol     (px_eol),
        .px_last    (px_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic pix(int g, int r, int c);
        logic [127:0] b;
        b = '0;
        if (g >= N || r >= H || c >= W) return 1'b0;
        for (int i = 0; i < N; i++) if (g == i) b = font[i];
        b = b << (r * W + c);
        return b[127];
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // rmode: 0 = px_ready always high, 1 = ready on every third cycle, 2 = random
    task automatic run_req(input int g, input int r, input bit m, input bit inv, input int rmode);
        px_t q[$];
        px_t exp, cur, held;
        int  last_row, rows, bubbles, first_v, last_c;
        bit  done, stalled, pr;
        last_row = (m && r < H) ? H - 1 : r;
        rows     = last_row - r + 1;
        for (int row = r; row <= last_row; row++) begin
            for (int c = 0; c < W; c++) begin
                exp.d = pix(g, row, c) ^ inv;
                exp.e = (c == W - 1);
                exp.l = (c == W - 1) && (row == last_row);
                q.push_back(exp);
            end
        end
        @(negedge clock);
        req_glyph  = 4'(g);
        req_row    = 4'(r);
        req_mode   = m;
        req_invert = inv;
        req_valid  = 1'b1;
        chk_bit("req_ready_idle", req_ready, 1'b1);
        @(posedge clock);
        done = 0; stalled = 0; bubbles = 0; first_v = -1; last_c = -1;
        held = '0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clock);
            cur.d = px_data; cur.e = px_eol; cur.l = px_last;
            chk_bit("busy_ready", req_ready, 1'b0);
            if (stalled) begin
                chk_bit("stall_valid", px_valid, 1'b1);
                chk_int("stall_stable", int'(cur), int'(held));
            end
            if (!px_valid) bubbles++;
            else if (first_v < 0) first_v = k;
            pr = (rmode == 0) ? 1'b1 : (rmode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
            px_ready   = pr;
            // Ignored traffic on the request port while busy.
            req_valid  = 1'($urandom_range(0, 1));
            req_glyph  = 4'($urandom_range(0, 15));
            req_row    = 4'($urandom_range(0, 15));
            req_mode   = 1'($urandom_range(0, 1));
            req_invert = 1'($urandom_range(0, 1));
            stalled = 0;
            if (px_valid && pr) begin
                chk_bit("pixel_expected", q.size() > 0, 1'b1);
                exp = (q.size() > 0) ? q.pop_front() : '0;
                chk_bit("px_data", cur.d, exp.d);
                chk_bit("px_eol", cur.e, exp.e);
                chk_bit("px_last", cur.l, exp.l);
                done = cur.l || (q.size() == 0);
                if (done) last_c = k;
            end else if (px_valid) begin
                stalled = 1;
                held    = cur;
            end
        end
        chk_bit("stream_done", done, 1'b1);
        chk_int("pixels_left", q.size(), 0);
        chk_int("fetch_bubbles", bubbles, rows);
        if (rmode == 0) begin
            chk_int("first_px_cycle", first_v, 1);
            chk_int("last_px_cycle", last_c, rows * (W + 1) - 1);
        end
        @(negedge clock);
        req_valid = 1'b0;
        px_ready  = 1'b0;
        chk_bit("after_valid", px_valid, 1'b0);
        chk_bit("after_ready", req_ready, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        rd_glyph   = '0;
        rd_address = '0;
        req_valid  = 1'b0;
        req_glyph  = '0;
        req_row    = '0;
        req_mode   = 1'b0;
        req_invert = 1'b0;
        px_ready   = 1'b0;
        repeat (3) @(negedge clock);
        chk_bit("rst_rd_q", rd_q, 1'b0);
        chk_bit("rst_px_valid", px_valid, 1'b0);
        chk_bit("rst_px_data", px_data, 1'b0);
        chk_bit("rst_px_eol", px_eol, 1'b0);
        chk_bit("rst_px_last", px_last, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk_bit("post_rst_ready", req_ready, 1'b1);
        chk_bit("post_rst_valid", px_valid, 1'b0);

        // Random port: glyph-8 sweep, then random addresses incl. bad glyphs.
        for (int a = 0; a < 128; a++) begin
            rd_glyph   = 4'd8;
            rd_address = 7'(a);
            @(negedge clock);
            chk_bit("rd_sweep", rd_q, pix(8, a / W, a % W));
        end
        for (int i = 0; i < 300; i++) begin
            int g, a;
            g = $urandom_range(0, 15);
            a = $urandom_range(0, 127);
            rd_glyph   = 4'(g);
            rd_address = 7'(a);
            @(negedge clock);
            chk_bit("rd_random", rd_q, pix(g, a / W, a % W));
        end

        run_req(8, 3, 1'b0, 1'b0, 0);   // single row
        run_req(8, 3, 1'b0, 1'b0, 1);   // backpressure
        run_req(8, 13, 1'b1, 1'b0, 0);  // tail of glyph, three blank rows
        run_req(12, 0, 1'b0, 1'b1, 0);  // out-of-range glyph, inverted
        run_req(0, 0, 1'b1, 1'b1, 2);   // whole glyph, random stalls

        // Reset in the middle of a row.
        @(negedge clock);
        req_glyph = 4'd8; req_row = 4'd3; req_mode = 1'b0; req_invert = 1'b0;
        req_valid = 1'b1; px_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk_bit("pre_rst_valid", px_valid, 1'b1);
        chk_bit("pre_rst_px4", px_data, pix(8, 3, 3));
        #2 reset = 1'b1;
        #1;
        chk_bit("abort_valid", px_valid, 1'b0);
        chk_bit("abort_data", px_data, 1'b0);
        chk_bit("abort_eol", px_eol, 1'b0);
        chk_bit("abort_last", px_last, 1'b0);
        @(negedge clock);
        reset    = 1'b0;
        px_ready = 1'b0;
        @(negedge clock);
        chk_bit("abort_ready", req_ready, 1'b1);
        chk_bit("abort_idle", px_valid, 1'b0);
        run_req(8, 4, 1'b0, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            run_req($urandom_range(0, 15), $urandom_range(0, 15),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
